nn_bus_arbiter: RTL and testbench
=================================

// Module: nn_bus_arbiter
// PURPOSE
//  Round-robin arbiter for the shared config/data-memory bus used by neuron calculation units and table fetch.
//  Each requester raises bus_request, waits for bus_grant, and holds the request while it owns the bus.
//  Drives the one-hot grant vector and the index used by the bus mux.
//  Sits between the requesters' bus_request/bus_grant pins and the config/data memory port.
// PARAMETERS
//  NREQ      4   number of requesters (2..16)
//  MAX_HOLD  16  cycle limit on one continuous grant; used only when ARB_TIMEOUT_EN is defined
//  IDW       4   width of grant_id; must be >= $clog2(NREQ)
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  reset        in   1     synchronous, active-low; reset==0 at posedge resets the block
//  bus_request  in   NREQ  per-requester request, level, held until the transfer is finished
//  bus_grant    out  NREQ  one-hot grant, registered
//  grant_id     out  IDW   index of current owner; valid when bus_busy=1
//  bus_busy     out  1     1 while any grant is asserted
//  timeout_evt  out  1     1-cycle pulse when a grant is revoked by timeout (tied 0 without macro)
// BEHAVIOUR
//  Reset values: bus_grant=0, grant_id=0, bus_busy=0, timeout_evt=0, state=ARB_IDLE, rr_ptr=0.
//  FSM states:
//   - ARB_IDLE: if |bus_request, pick the winner with rr_pick starting at rr_ptr and go to ARB_GRANT.
//     The grant register is loaded on the same edge, so latency is request-to-grant = 1 cycle.
//   - ARB_GRANT: hold bus_grant/grant_id stable while the owner's bus_request=1.
//     When the owner's bus_request=0 (sampled), clear the grant, set rr_ptr=(owner+1)%NREQ, and go to ARB_TURN.
//   - ARB_TURN: one dead cycle with no grant. Go to ARB_IDLE, or straight to ARB_GRANT if |bus_request.
//     The winner is picked from the updated rr_ptr.
//  Round robin: the search starts at rr_ptr and wraps past NREQ-1 to 0.
//   - The last owner has lowest priority next round.
//   - A continuously requesting unit waits at most NREQ-1 tenures.
//  Requests from non-owners in ARB_GRANT are ignored; they are not latched. A pulse dropped before grant is lost.
//  Owner drops request and another raises request on the same edge: the turnaround cycle still occurs.
//  All requests drop at once: ARB_GRANT -> ARB_TURN -> ARB_IDLE; the bus is idle after 2 cycles.
//  Reset mid-grant: bus_grant=0 on the reset edge; no partial state is kept.
//  Exactly 0 or 1 bit of bus_grant is set in every cycle (onehot0).
//  bus_busy == |bus_grant.
// CONFIGURATION
//  ARB_TIMEOUT_EN defined:
//   - A hold counter (width $clog2(MAX_HOLD+1)) clears when entering ARB_GRANT and increments each cycle in ARB_GRANT.
//   - When the count reaches MAX_HOLD-1 with the owner still requesting, the grant is revoked.
//     The grant therefore lasts exactly MAX_HOLD cycles.
//   - On revocation: timeout_evt pulses, rr_ptr advances past the owner, and the FSM goes to ARB_TURN.
//     The owner may win again later by round robin.
//  ARB_TIMEOUT_EN not defined: no counter; the grant is held indefinitely; timeout_evt is constant 0.
// STRUCTURE
//  Package nn_bus_pkg:
//   - typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t
//   - localparam NREQ_MAX=16
//   - function onehot_to_idx
//  Sub-module rr_pick (combinational):
//   - inputs req[NREQ], ptr[IDW]; outputs hit, idx[IDW], onehot[NREQ]
//   - implemented as a double-width masked priority encoder
//  Top: a single always_ff for state/grant/rr_ptr/counter and an always_comb for next state.
// TESTING
//  T1 reset: hold reset=0 for 3 cycles with bus_request=4'b1111 -> bus_grant=0, bus_busy=0 throughout.
//     Release reset -> bus_grant=4'b0001 one cycle later.
//  T2 single requester: bus_request=4'b0100 at cycle 0 -> bus_grant=4'b0100, grant_id=2 at cycle 1.
//     Drop the request at cycle 5 -> bus_grant=0 at cycle 6.
//  T3 fairness: all 4 request; each owner drops the request 3 cycles after its grant.
//     -> grant order 0,1,2,3,0, with exactly one dead cycle between tenures.
//  T4 wrap: rr_ptr=3 after owner 2 releases; bus_request=4'b1001 -> requester 3 is granted, then 0.
//  T5 timeout (ARB_TIMEOUT_EN, MAX_HOLD=16): requester 1 holds forever while 0 requests.
//     -> grant to 1 for 16 cycles, timeout_evt=1 for one cycle, dead cycle, then grant to 0.
//  T6 reset mid-grant: reset=0 while bus_grant=4'b0010 -> bus_grant=0 at the next edge, rr_ptr=0.
//     Assertion: onehot0(bus_grant) holds in all cycles.

Source files
------------

// File: rtl/nn_bus_pkg.sv
// Shared types and helpers for the config/data-memory bus arbiter.
package nn_bus_pkg;

    typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_t;

    localparam int NREQ_MAX = 16;
    localparam int IDX_W    = $clog2(NREQ_MAX);

    // OR-reduction encoder: only correct for one-hot or all-zero input.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NREQ_MAX-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NREQ_MAX; i++) begin
            if (oh[i]) idx = idx | IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/nn_bus_arbiter_rr_pick.sv
// Combinational round-robin winner search starting at ptr and wrapping to 0.
module rr_pick
    import nn_bus_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            hit,
    output logic [IDW-1:0]  idx,
    output logic [NREQ-1:0] onehot
);

    logic [NREQ-1:0]   mask;
    logic [2*NREQ-1:0] dbl;

    // Lower copy keeps only requesters at or above ptr; the upper copy supplies the wrap.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            mask[i] = (i >= int'(ptr));
        end
        dbl = {req, req & mask};
    end

    always_comb begin
        hit    = |req;
        idx    = '0;
        onehot = '0;
        for (int i = 2*NREQ-1; i >= 0; i--) begin
            if (dbl[i]) idx = (i >= NREQ) ? IDW'(i - NREQ) : IDW'(i);
        end
        if (hit) onehot = NREQ'(1) << idx;
    end

endmodule

// File: rtl/nn_bus_arbiter.sv
// Round-robin arbiter for the shared config/data-memory bus.
// Optional grant timeout is enabled by defining ARB_TIMEOUT_EN.
module nn_bus_arbiter
    import nn_bus_pkg::*;
#(
    parameter int NREQ     = 4,
    parameter int MAX_HOLD = 16,
    parameter int IDW      = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] bus_request,
    output logic [NREQ-1:0] bus_grant,
    output logic [IDW-1:0]  grant_id,
    output logic            bus_busy,
    output logic            timeout_evt
);

    arb_state_t      state, state_nx;
    logic [NREQ-1:0] grant_nx;
    logic [IDW-1:0]  grant_id_nx;
    logic [IDW-1:0]  rr_ptr, rr_ptr_nx;

    logic            pick_hit;
    logic [IDW-1:0]  pick_idx;
    logic [NREQ-1:0] pick_oh;
    logic            owner_req;
    logic [IDW-1:0]  owner_idx, owner_next;
    logic            revoke;

    rr_pick #(
        .NREQ(NREQ),
        .IDW (IDW)
    ) u_pick (
        .req   (bus_request),
        .ptr   (rr_ptr),
        .hit   (pick_hit),
        .idx   (pick_idx),
        .onehot(pick_oh)
    );

    assign owner_req  = |(bus_request & bus_grant);
    assign owner_idx  = IDW'(onehot_to_idx(NREQ_MAX'(bus_grant)));
    assign owner_next = (owner_idx == IDW'(NREQ-1)) ? '0 : owner_idx + IDW'(1);
    assign bus_busy   = |bus_grant;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD+1);
    logic [CNT_W-1:0] hold_cnt;

    // Revoking at MAX_HOLD-1 makes the visible grant exactly MAX_HOLD cycles long.
    assign revoke = owner_req && (hold_cnt == CNT_W'(MAX_HOLD-1));
`else
    assign revoke      = 1'b0;
    assign timeout_evt = 1'b0;
`endif

    always_comb begin
        state_nx    = state;
        grant_nx    = bus_grant;
        grant_id_nx = grant_id;
        rr_ptr_nx   = rr_ptr;
        case (state)
            ARB_IDLE, ARB_TURN: begin
                if (pick_hit) begin
                    state_nx    = ARB_GRANT;
                    grant_nx    = pick_oh;
                    grant_id_nx = pick_idx;
                end else begin
                    state_nx = ARB_IDLE;
                    grant_nx = '0;
                end
            end
            ARB_GRANT: begin
                if (!owner_req || revoke) begin
                    state_nx  = ARB_TURN;
                    grant_nx  = '0;
                    rr_ptr_nx = owner_next;
                end
            end
            default: begin
                state_nx = ARB_IDLE;
                grant_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ARB_IDLE;
            bus_grant <= '0;
            grant_id  <= '0;
            rr_ptr    <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt    <= '0;
            timeout_evt <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            bus_grant <= grant_nx;
            grant_id  <= grant_id_nx;
            rr_ptr    <= rr_ptr_nx;
`ifdef ARB_TIMEOUT_EN
            // Counter restarts on every entry into ARB_GRANT.
            hold_cnt    <= (state == ARB_GRANT) ? hold_cnt + CNT_W'(1) : '0;
            timeout_evt <= (state == ARB_GRANT) && revoke;
`endif
        end
    end

endmodule

// File: tb/tb_nn_bus_arbiter.sv
// Self-checking bench for nn_bus_arbiter: vector table, hand sequences, random run against a model.
module tb_nn_bus_arbiter;

    localparam int NREQ     = 4;
    localparam int MAX_HOLD = 16;
    localparam int IDW      = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] bus_request;
    logic [NREQ-1:0] bus_grant;
    logic [IDW-1:0]  grant_id;
    logic            bus_busy;
    logic            timeout_evt;

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic [3:0] exp_grant;
        logic [3:0] exp_id;
    } vec_t;

    typedef struct {
        logic [3:0] grant;
        logic [3:0] id;
        logic       id_chk;
        logic       tevt;
        string      tag;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    int         m_state;
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    logic [3:0] m_id;

    nn_bus_arbiter #(
        .NREQ    (NREQ),
        .MAX_HOLD(MAX_HOLD),
        .IDW     (IDW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus_request(bus_request),
        .bus_grant  (bus_grant),
        .grant_id   (grant_id),
        .bus_busy   (bus_busy),
        .timeout_evt(timeout_evt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (!$onehot0(bus_grant)) begin
                errors++;
                $display("FAIL onehot0: bus_grant=%b", bus_grant);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic compare_pending();
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".grant"}, 32'(bus_grant), 32'(e.grant));
            check({e.tag, ".busy"}, 32'(bus_busy), 32'(e.grant != 4'b0));
            if (e.id_chk) check({e.tag, ".id"}, 32'(grant_id), 32'(e.id));
            check({e.tag, ".tevt"}, 32'(timeout_evt), 32'(e.tevt));
        end
    endtask

    // Inputs applied at negedge; their effect is compared at the following negedge.
    task automatic step(input string tag, input logic r, input logic [3:0] q,
                        input logic [3:0] eg, input logic [3:0] eid, input logic ete);
        exp_t e;
        @(negedge clk);
        compare_pending();
        reset       = r;
        bus_request = q;
        e.grant  = eg;
        e.id     = eid;
        e.id_chk = (eg != 4'b0) || !r;
        e.tevt   = ete;
        e.tag    = tag;
        sb.push_back(e);
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] eg, input logic [3:0] eid);
        vec_t v;
        v.rst_n     = r;
        v.req       = q;
        v.exp_grant = eg;
        v.exp_id    = eid;
        tbl.push_back(v);
    endtask

    task automatic model_step(input logic r, input logic [3:0] q,
                              output logic [3:0] eg, output logic [3:0] eid, output logic ete);
        int w;
        ete = 1'b0;
        if (!r) begin
            m_state = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_id    = 4'd0;
        end else if (m_state == 1) begin
            if (!q[m_owner]) begin
                m_state = 2;
                m_ptr   = (m_owner + 1) % NREQ;
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_cnt == MAX_HOLD - 1) begin
                m_state = 2;
                m_ptr   = (m_owner + 1) % NREQ;
                ete     = 1'b1;
            end
`endif
            else m_cnt++;
        end else begin
            w = -1;
            for (int k = NREQ - 1; k >= 0; k--) begin
                if (q[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            if (w >= 0) begin
                m_state = 1;
                m_owner = w;
                m_id    = w[3:0];
                m_cnt   = 0;
            end else begin
                m_state = 0;
            end
        end
        eg  = (m_state == 1) ? 4'(1 << m_owner) : 4'b0;
        eid = m_id;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] q, msk, eg, eid;
        logic       r, ete;

        reset       = 1'b0;
        bus_request = 4'b0;

        // T1 reset held with all requesting, release, then everyone drops
        add(0, 4'b1111, 4'b0000, 4'd0);
        add(0, 4'b1111, 4'b0000, 4'd0);
        add(0, 4'b1111, 4'b0000, 4'd0);
        add(1, 4'b1111, 4'b0001, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        // T2 single requester 2, held 5 cycles
        add(1, 4'b0100, 4'b0100, 4'd2);
        for (int i = 0; i < 4; i++) add(1, 4'b0100, 4'b0100, 4'd2);
        add(1, 4'b0000, 4'b0000, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        // T4 wrap from rr_ptr=3
        add(1, 4'b1001, 4'b1000, 4'd3);
        add(1, 4'b1001, 4'b1000, 4'd3);
        add(1, 4'b0001, 4'b0000, 4'd0);
        add(1, 4'b0001, 4'b0001, 4'd0);
        add(1, 4'b0001, 4'b0001, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        // T3 fairness from reset: order 0,1,2,3,0 with one dead cycle each
        add(0, 4'b0000, 4'b0000, 4'd0);
        for (int o = 0; o < 4; o++) begin
            add(1, 4'b1111, 4'(1 << o), 4'(o));
            add(1, 4'b1111, 4'(1 << o), 4'(o));
            add(1, 4'b1111, 4'(1 << o), 4'(o));
            add(1, 4'b1111 & ~4'(1 << o), 4'b0000, 4'd0);
        end
        add(1, 4'b1111, 4'b0001, 4'd0);
        // T6 reset mid-grant clears grant and rr_ptr
        add(1, 4'b1110, 4'b0000, 4'd0);
        add(1, 4'b0010, 4'b0010, 4'd1);
        add(1, 4'b0010, 4'b0010, 4'd1);
        add(0, 4'b0010, 4'b0000, 4'd0);
        add(1, 4'b1001, 4'b0001, 4'd0);
        // Hand-off on the same edge still inserts a dead cycle; non-owner pulses are lost
        add(1, 4'b1000, 4'b0000, 4'd0);
        add(1, 4'b1000, 4'b1000, 4'd3);
        add(1, 4'b1100, 4'b1000, 4'd3);
        add(1, 4'b0110, 4'b0000, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);
        add(1, 4'b0000, 4'b0000, 4'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].rst_n, tbl[i].req, tbl[i].exp_grant, tbl[i].exp_id, 1'b0);
            if (i == 1) mon_en = 1'b1;
        end

        step("hold_rst", 0, 4'b0000, 4'b0000, 4'd0, 1'b0);
`ifdef ARB_TIMEOUT_EN
        // T5 requester 1 holds forever while 0 waits
        step("t5_g", 1, 4'b0010, 4'b0010, 4'd1, 1'b0);
        for (int i = 0; i < MAX_HOLD - 1; i++) step($sformatf("t5_h%0d", i), 1, 4'b0011, 4'b0010, 4'd1, 1'b0);
        step("t5_evt", 1, 4'b0011, 4'b0000, 4'd0, 1'b1);
        step("t5_next", 1, 4'b0011, 4'b0001, 4'd0, 1'b0);
        step("t5_rel", 1, 4'b0000, 4'b0000, 4'd0, 1'b0);
        step("t5_idle", 1, 4'b0000, 4'b0000, 4'd0, 1'b0);
`else
        // Without the timeout a long grant is never revoked
        step("hold_g", 1, 4'b0100, 4'b0100, 4'd2, 1'b0);
        for (int i = 0; i < MAX_HOLD + 4; i++) step($sformatf("hold_h%0d", i), 1, 4'b0101, 4'b0100, 4'd2, 1'b0);
        step("hold_rel", 1, 4'b0001, 4'b0000, 4'd0, 1'b0);
        step("hold_next", 1, 4'b0001, 4'b0001, 4'd0, 1'b0);
        step("hold_end", 1, 4'b0000, 4'b0000, 4'd0, 1'b0);
`endif

        // Random traffic against the reference model
        q = 4'b0;
        model_step(1'b0, q, eg, eid, ete);
        step("rnd_rst", 1'b0, q, eg, eid, ete);
        for (int n = 0; n < 600; n++) begin
            r   = ($urandom_range(0, 80) != 0);
            msk = 4'b0;
            for (int b = 0; b < NREQ; b++) begin
                if ($urandom_range(0, 5) == 0) msk[b] = 1'b1;
            end
            q = q ^ msk;
            model_step(r, q, eg, eid, ete);
            step($sformatf("rnd%0d", n), r, q, eg, eid, ete);
        end

        @(negedge clk);
        compare_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
